// File: rtl/axis_burst_pkg.sv
// Shared types and constants for the AXI-Stream burst command generator.
// The command struct is sized for the widest supported address/length fields.
package axis_burst_pkg;

   localparam logic [31:0] BOUNDARY_BYTES = 32'd4096;
   localparam int          CMD_ADDR_W     = 64;
   localparam int          CMD_LEN_W      = 16;

   typedef struct packed {
      logic [CMD_ADDR_W-1:0] addr;
      logic [CMD_LEN_W-1:0]  len;
   } cmd_t;

   typedef enum logic {
      ST_SOP = 1'b0,
      ST_MID = 1'b1
   } state_t;

endpackage

// File: rtl/axis_burst_cmd_reg.sv
// Command output register: holds one burst command until the consumer accepts it.
module axis_burst_cmd_reg
   import axis_burst_pkg::*;
#(
   parameter int ASIZE = 32,
   parameter int LSIZE = 8
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             load,
   input  logic [ASIZE-1:0] load_addr,
   input  logic [LSIZE-1:0] load_len,
   input  logic             cmd_ready,
   output logic [ASIZE-1:0] cmd_addr,
   output logic [LSIZE-1:0] cmd_len,
   output logic             cmd_valid
);

   cmd_t cmd_r;
   logic valid_r;

   // Load a new command (wins over acceptance), otherwise drop valid once accepted.
   always_ff @(posedge clock) begin
      if (rst) begin
         cmd_r   <= '{addr: {CMD_ADDR_W{1'b0}}, len: {CMD_LEN_W{1'b0}}};
         valid_r <= 1'b0;
      end else if (load) begin
         cmd_r   <= '{addr: CMD_ADDR_W'(load_addr), len: CMD_LEN_W'(load_len)};
         valid_r <= 1'b1;
      end else if (cmd_ready) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign cmd_addr  = cmd_r.addr[ASIZE-1:0];
   assign cmd_len   = cmd_r.len[LSIZE-1:0];
   assign cmd_valid = valid_r;

endmodule

// File: rtl/axis_burst_cmd_gen.sv
// AXI-Stream pass-through that cuts packets into bursts and issues one command per burst.
// Define AXIS_BURST_4K_GUARD_EN to keep bursts from crossing 4 KB address boundaries.
module axis_burst_cmd_gen
   import axis_burst_pkg::*;
#(
   parameter int DSIZE = 32,
   parameter int ASIZE = 32,
   parameter int LSIZE = 8
) (
   input  logic               clock,
   input  logic               rst,
   input  logic [ASIZE-1:0]   start_addr,
   input  logic [LSIZE:0]     max_len,
   input  logic [DSIZE-1:0]   s_axis_tdata,
   input  logic [DSIZE/8-1:0] s_axis_tkeep,
   input  logic               s_axis_tlast,
   input  logic               s_axis_tvalid,
   output logic               s_axis_tready,
   output logic [DSIZE-1:0]   m_axis_tdata,
   output logic [DSIZE/8-1:0] m_axis_tkeep,
   output logic               m_axis_tlast,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic [ASIZE-1:0]   cmd_addr,
   output logic [LSIZE-1:0]   cmd_len,
   output logic               cmd_valid,
   input  logic               cmd_ready
);

   localparam logic [31:0] BYTES = 32'(DSIZE / 8);

   state_t           state_r;
   logic [ASIZE-1:0] burst_addr_r;
   logic [LSIZE:0]   limit_r;
   logic [LSIZE-1:0] count_r;

   logic [ASIZE-1:0] addr_s;
   logic [ASIZE-1:0] next_addr_s;
   logic [LSIZE:0]   limit_s;
   logic [31:0]      room_s;
   logic             closing_s;
   logic             stall_s;
   logic             xfer_s;
`ifdef AXIS_BURST_4K_GUARD_EN
   logic [31:0]      bound_s;
`endif

   function automatic logic [LSIZE:0] clamp_len(input logic [LSIZE:0] len);
      logic [LSIZE:0] max_v;
      max_v        = {(LSIZE+1){1'b0}};
      max_v[LSIZE] = 1'b1;
      if (len == {(LSIZE+1){1'b0}}) begin
         clamp_len = {{LSIZE{1'b0}}, 1'b1};
      end else if (len > max_v) begin
         clamp_len = max_v;
      end else begin
         clamp_len = len;
      end
   endfunction

   // Burst geometry of the current beat; the first beat of a packet uses the live inputs.
   always_comb begin
      addr_s  = (state_r == ST_SOP) ? start_addr : burst_addr_r;
      limit_s = (state_r == ST_SOP) ? clamp_len(max_len) : limit_r;
`ifdef AXIS_BURST_4K_GUARD_EN
      bound_s = (BOUNDARY_BYTES - {20'd0, addr_s[11:0]}) / BYTES;
      bound_s = (bound_s == 32'd0) ? 32'd1 : bound_s;
      room_s  = (bound_s < 32'(limit_s)) ? bound_s : 32'(limit_s);
`else
      room_s  = 32'(limit_s);
`endif
      closing_s   = s_axis_tlast | ((32'(count_r) + 32'd1) == room_s);
      stall_s     = rst | (closing_s & cmd_valid & ~cmd_ready);
      xfer_s      = s_axis_tvalid & m_axis_tready & ~stall_s;
      next_addr_s = addr_s + ASIZE'((32'(count_r) + 32'd1) * BYTES);
   end

   assign s_axis_tready = m_axis_tready & ~stall_s;
   assign m_axis_tvalid = s_axis_tvalid & ~stall_s;
   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tkeep  = s_axis_tkeep;
   assign m_axis_tlast  = closing_s;

   // Packet/burst tracking: a partial burst is simply forgotten on reset.
   always_ff @(posedge clock) begin
      if (rst) begin
         state_r      <= ST_SOP;
         burst_addr_r <= {ASIZE{1'b0}};
         limit_r      <= {{LSIZE{1'b0}}, 1'b1};
         count_r      <= {LSIZE{1'b0}};
      end else if (xfer_s) begin
         state_r      <= s_axis_tlast ? ST_SOP : ST_MID;
         limit_r      <= limit_s;
         burst_addr_r <= closing_s ? next_addr_s : addr_s;
         count_r      <= closing_s ? {LSIZE{1'b0}} : count_r + LSIZE'(1'b1);
      end else begin
         state_r      <= state_r;
         limit_r      <= limit_r;
         burst_addr_r <= burst_addr_r;
         count_r      <= count_r;
      end
   end

   axis_burst_cmd_reg #(
      .ASIZE (ASIZE),
      .LSIZE (LSIZE)
   ) u_cmd_reg (
      .clock     (clock),
      .rst       (rst),
      .load      (xfer_s & closing_s),
      .load_addr (addr_s),
      .load_len  (count_r),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .cmd_valid (cmd_valid)
   );

endmodule

// File: tb/tb_axis_burst_cmd_gen.sv
// Randomized bench for axis_burst_cmd_gen against a packet-level burst-splitting model.
// Honours AXIS_BURST_4K_GUARD_EN the same way the design does.
module tb_axis_burst_cmd_gen;

   logic        clock = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] start_addr = 32'd0;
   logic [8:0]  max_len = 9'd0;
   logic [31:0] s_axis_tdata = 32'd0;
   logic [3:0]  s_axis_tkeep = 4'd0;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [31:0] m_axis_tdata;
   logic [3:0]  m_axis_tkeep;
   logic        m_axis_tlast;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic        cmd_valid;
   logic        cmd_ready = 1'b0;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int out_beats = 0;
   int valid_pct = 100;
   int mready_pct = 100;
   int cready_pct = 100;
   bit mon_data_en = 1'b1;

   logic [35:0] exp_data_q[$];
   bit          exp_last_q[$];
   logic [39:0] exp_cmd_q[$];
   int          cmd_cyc_q[$];

   axis_burst_cmd_gen #(.DSIZE(32), .ASIZE(32), .LSIZE(8)) dut (
      .clock(clock), .rst(rst), .start_addr(start_addr), .max_len(max_len),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   // Reference model: split one packet into bursts from the address/limit rules.
   task automatic model_packet(input logic [31:0] addr, input logic [8:0] ml, input int n);
      int lim, rem, room, blen, bnd;
      logic [31:0] a;
      lim = (ml == 9'd0) ? 1 : ((ml > 9'd256) ? 256 : int'(ml));
      a = addr;
      rem = n;
      while (rem > 0) begin
         room = lim;
`ifdef AXIS_BURST_4K_GUARD_EN
         bnd = int'((32'd4096 - (a % 32'd4096)) / 32'd4);
         if (bnd < 1) bnd = 1;
         if (bnd < room) room = bnd;
`else
         bnd = 0;
`endif
         blen = (rem < room) ? rem : room;
         exp_cmd_q.push_back({a, 8'(blen - 1)});
         for (int k = 0; k < blen; k++) exp_last_q.push_back(k == blen - 1);
         a = a + 32'(blen * 4);
         rem = rem - blen;
      end
   endtask

   // Drives one packet; entered and left just after a rising edge.
   task automatic send_packet(input logic [31:0] addr, input logic [8:0] ml, input int n);
      logic [31:0] d;
      logic [3:0]  k;
      bit acc;
      int waits;
      model_packet(addr, ml, n);
      start_addr = addr;
      max_len = ml;
      for (int i = 0; i < n; i++) begin
         d = $urandom;
         k = 4'($urandom);
         exp_data_q.push_back({k, d});
         s_axis_tdata = d;
         s_axis_tkeep = k;
         s_axis_tlast = (i == n - 1);
         s_axis_tvalid = 1'b0;
         waits = 0;
         acc = 1'b0;
         while (!acc) begin
            if (!s_axis_tvalid) s_axis_tvalid = ($urandom_range(1, 100) <= valid_pct);
            @(negedge clock);
            acc = s_axis_tvalid && s_axis_tready;
            @(posedge clock);
            #1;
            if (!acc) begin
               waits++;
               if (waits > 3000) begin
                  check_val("drv_timeout", 64'(waits), 64'd0);
                  s_axis_tvalid = 1'b0;
                  return;
               end
            end
         end
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      forever begin
         @(posedge clock);
         #1;
         m_axis_tready = ($urandom_range(1, 100) <= mready_pct);
         cmd_ready = ($urandom_range(1, 100) <= cready_pct);
      end
   end

   // Output monitors: stream beats and accepted commands against the model queues.
   always @(negedge clock) begin
      if (!rst && mon_data_en && m_axis_tvalid && m_axis_tready) begin
         out_beats++;
         if (exp_data_q.size() == 0 || exp_last_q.size() == 0) begin
            check_val("beat_unexpected", 64'(exp_data_q.size()), 64'd1);
         end else begin
            logic [35:0] e;
            bit l;
            e = exp_data_q.pop_front();
            l = exp_last_q.pop_front();
            check_val("tdata", 64'(m_axis_tdata), 64'(e[31:0]));
            check_val("tkeep", 64'(m_axis_tkeep), 64'(e[35:32]));
            check_val("tlast", 64'(m_axis_tlast), 64'(l));
         end
      end
      if (!rst && cmd_valid && cmd_ready) begin
         cmd_cyc_q.push_back(cyc);
         if (exp_cmd_q.size() == 0) begin
            check_val("cmd_unexpected", 64'(exp_cmd_q.size()), 64'd1);
         end else begin
            logic [39:0] c;
            c = exp_cmd_q.pop_front();
            check_val("cmd_addr", 64'(cmd_addr), 64'(c[39:8]));
            check_val("cmd_len", 64'(cmd_len), 64'(c[7:0]));
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, waited;
      rst = 1'b1;
      s_axis_tvalid = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_val("rst_s_tready", 64'(s_axis_tready), 64'd0);
      check_val("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check_val("rst_cmd_valid", 64'(cmd_valid), 64'd0);
      check_val("rst_cmd_addr", 64'(cmd_addr), 64'd0);
      check_val("rst_cmd_len", 64'(cmd_len), 64'd0);
      @(posedge clock);
      #1;
      rst = 1'b0;
      s_axis_tvalid = 1'b0;

      // Directed geometry cases with random flow control.
      valid_pct = 70; mready_pct = 70; cready_pct = 60;
      send_packet(32'h0000_1000, 9'd16, 40);
      send_packet(32'h0000_0FF0, 9'd16, 10);
      send_packet(32'h0000_3000, 9'd0, 3);
      send_packet(32'h0001_0000, 9'd300, 260);

      // Back-to-back single-beat packets.
      valid_pct = 100; mready_pct = 100; cready_pct = 100;
      idle(6);
      send_packet(32'h0000_0200, 9'd16, 1);
      send_packet(32'h0000_0300, 9'd16, 1);
      idle(4);
      n = cmd_cyc_q.size();
      check_val("b2b_cmd_count", 64'(n >= 2), 64'd1);
      if (n >= 2) check_val("b2b_gap", 64'(cmd_cyc_q[n-1] - cmd_cyc_q[n-2]), 64'd1);

      // Second burst closes while the first command is still waiting.
      cready_pct = 0;
      idle(2);
      n = out_beats;
      fork
         send_packet(32'h0000_2000, 9'd4, 8);
         begin
            repeat (20) @(negedge clock);
            check_val("stall_s_tready", 64'(s_axis_tready), 64'd0);
            check_val("stall_m_tvalid", 64'(m_axis_tvalid), 64'd0);
            check_val("stall_beats", 64'(out_beats - n), 64'd7);
            check_val("stall_cmd_valid", 64'(cmd_valid), 64'd1);
            check_val("stall_cmd_addr", 64'(cmd_addr), 64'h2000);
            cready_pct = 100;
         end
      join
      idle(6);
      check_val("pre_rst_cmds_empty", 64'(exp_cmd_q.size()), 64'd0);

      // Reset on beat 5 of a 12-beat packet.
      mon_data_en = 1'b0;
      start_addr = 32'h0000_5000;
      max_len = 9'd16;
      s_axis_tlast = 1'b0;
      s_axis_tvalid = 1'b1;
      idle(4);
      rst = 1'b1;
      @(negedge clock);
      check_val("mid_rst_s_tready", 64'(s_axis_tready), 64'd0);
      check_val("mid_rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      idle(2);
      rst = 1'b0;
      s_axis_tvalid = 1'b0;
      @(negedge clock);
      check_val("post_rst_cmd_valid", 64'(cmd_valid), 64'd0);
      @(posedge clock);
      #1;
      mon_data_en = 1'b1;
      send_packet(32'h0000_6000, 9'd4, 3);

      // Random packets.
      valid_pct = 75; mready_pct = 70; cready_pct = 50;
      for (int p = 0; p < 25; p++) begin
         logic [31:0] a;
         logic [8:0] ml;
         a = $urandom;
         ml = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 12));
         send_packet(a, ml, int'($urandom_range(1, 40)));
      end

      // Drain and confirm nothing lost.
      mready_pct = 100; cready_pct = 100;
      waited = 0;
      while ((exp_cmd_q.size() != 0 || exp_data_q.size() != 0) && waited < 2000) begin
         @(posedge clock);
         waited++;
      end
      idle(2);
      check_val("end_data_empty", 64'(exp_data_q.size()), 64'd0);
      check_val("end_cmd_empty", 64'(exp_cmd_q.size()), 64'd0);
      check_val("end_last_empty", 64'(exp_last_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/axis_burst_cmd_gen.md
AXIS_BURST_CMD_GEN -- requirements
Module: axis_burst_cmd_gen

Interface
REQ-001 Parameter DSIZE, default 32: data width in bits, multiple of 8, 8..1024.
REQ-002 Parameter ASIZE, default 32: byte-address width.
REQ-003 Parameter LSIZE, default 8: burst-length field width; maximum burst is 2**LSIZE beats.
REQ-004 Port clock, input, 1: single clock for all logic.
REQ-005 Port rst, input, 1: synchronous reset, active-high.
REQ-006 Ports start_addr input ASIZE and max_len input LSIZE+1: packet base byte address and burst beat limit, both sampled on a packet's first beat.
REQ-007 Ports s_axis_tdata DSIZE, s_axis_tkeep DSIZE/8, s_axis_tlast 1, s_axis_tvalid 1 (inputs); s_axis_tready 1 (output): input stream.
REQ-008 Ports m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid (outputs); m_axis_tready (input): burst-delimited output stream.
REQ-009 Ports cmd_addr ASIZE, cmd_len LSIZE, cmd_valid 1 (outputs); cmd_ready 1 (input): one command per burst, cmd_len = beats-1 (AXI4 AxLEN encoding).

Function
REQ-010 Data path SHALL be zero-latency pass-through: m_axis_tdata/tkeep equal s_axis_tdata/tkeep; m_axis_tvalid = s_axis_tvalid & ~stall; s_axis_tready = m_axis_tready & ~stall.
REQ-011 stall SHALL be 1 only when the current beat closes a burst and cmd_valid=1 with cmd_ready=0.
REQ-012 FSM states SOP and MID; reset state SOP; SOP->MID on a transferred non-closing beat; MID->SOP on a transferred beat that ends the input packet (s_axis_tlast).
REQ-013 In SOP, a transferred beat SHALL latch burst address = start_addr and limit = max_len, with max_len=0 treated as 1 and max_len>2**LSIZE clamped to 2**LSIZE.
REQ-014 Burst room SHALL be min(limit, beats to the next 4 KB boundary), where beats to boundary = (4096 - addr[11:0]) / (DSIZE/8), rounded down, minimum 1.
REQ-015 Beat counter SHALL count transferred beats in the current burst; a beat closes the burst when count+1 == room or s_axis_tlast=1.
REQ-016 m_axis_tlast SHALL be 1 on a closing beat and 0 otherwise.
REQ-017 On a transferred closing beat, the block SHALL load cmd_addr = burst address, cmd_len = count, cmd_valid = 1 on the next edge.
REQ-018 After each closing beat, the burst address SHALL advance by (count+1)*(DSIZE/8), modulo 2**ASIZE, and the counter SHALL clear; when the packet continues, the next burst starts in state MID.
REQ-019 cmd_valid SHALL clear on cmd_valid&cmd_ready unless a new command loads in the same cycle; a simultaneous load wins.
REQ-020 Commands SHALL never be dropped or reordered; bursts and commands SHALL correspond one-to-one and in order.

Reset
REQ-021 While rst=1: state=SOP, counter=0, cmd_valid=0, cmd_addr=0, cmd_len=0, and stall is forced high so that s_axis_tready=0 and m_axis_tvalid=0.
REQ-022 A reset asserted mid-packet SHALL discard the partial burst with no command; the first beat after reset SHALL be treated as a new packet start.

Configuration
REQ-023 Macro AXIS_BURST_4K_GUARD_EN: when defined, REQ-014 applies in full; when undefined, room = limit only and bursts may cross 4 KB boundaries.

Structure
REQ-024 Package axis_burst_pkg SHALL hold the command struct typedef (addr, len), the constant BOUNDARY_BYTES=4096, and the state enum.
REQ-025 The command output register with its valid/ready handling SHALL be a sub-module, axis_burst_cmd_reg; all other logic is flat.

Verification (DSIZE=32 unless stated otherwise)
REQ-026 start_addr=0x1000, max_len=16, 40-beat packet -> bursts of 16/16/8 beats; cmds (0x1000,15), (0x1040,15), (0x1080,7); m_axis_tlast on beats 16, 32, 40.
REQ-027 start_addr=0x0FF0, max_len=16, 10-beat packet with the guard enabled -> cmds (0x0FF0,3), (0x1000,5); without the guard -> single cmd (0x0FF0,9).
REQ-028 cmd_ready held 0 for 20 cycles while a second burst closes -> closing beat stalls (s_axis_tready=0) until the first cmd is accepted; no beat lost.
REQ-029 Single-beat packets back-to-back, cmd_ready=1, start_addr 0x200 then 0x300 -> cmds (0x200,0), (0x300,0) on consecutive cycles; tlast on every beat.
REQ-030 rst pulsed on beat 5 of a 12-beat packet, max_len=16 -> no cmd issued; next packet beat 1 latches the new start_addr.
REQ-031 max_len=0 and max_len=300 with LSIZE=8 -> bursts of 1 beat and 256 beats respectively.
